// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-requester ALU arbiter/controller:
// FSM state encoding, default function-code width and the settle-counter width.
package alu_arb_pkg;

  // Default width of the ALU function code.
  localparam int FUN_W_DEF = 6;

  // Settle counter width; holds EXEC_CYCLES-1 for EXEC_CYCLES up to 15.
  localparam int CNT_W = 4;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // Select one of two values by requester id.
  function automatic logic [31:0] pick32(input logic id, input logic [31:0] v0, input logic [31:0] v1);
    return id ? v1 : v0;
  endfunction

endpackage

// File: rtl/alu_arb_grant.sv
// Grant selection between the two requesters.
// Default build: round-robin on ties, using a last-grant pointer that moves on acceptance.
// With ALU_ARB_FIXED_PRIO_EN defined: requester 0 always wins ties and no pointer exists.
// A lone valid requester is always granted.
module alu_arb_grant
  import alu_arb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic accept_i,
  output logic gnt_id_o
);

`ifdef ALU_ARB_FIXED_PRIO_EN

  // Requester 1 only wins when requester 0 is not asking.
  assign gnt_id_o = valid1_i & ~valid0_i;

  // Clock, reset and accept have no role without a pointer.
  logic unused_ok;
  assign unused_ok = &{1'b0, clk, reset, accept_i};

`else

  logic last_q;
  logic last_d;

  // Tie goes to the requester that did not win last time; a lone requester always wins.
  always_comb begin
    gnt_id_o = valid1_i;
    if (valid0_i && valid1_i) begin
      gnt_id_o = ~last_q;
    end
  end

  // Pointer follows the requester whose request was just accepted.
  always_comb begin
    last_d = last_q;
    if (accept_i) begin
      last_d = gnt_id_o;
    end
  end

  // Pointer register; reset value makes requester 0 win the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

`endif

endmodule

// File: rtl/alu_arb_ctrl.sv
// Two-requester front end for a shared external ALU.
// Accepts one request at a time, holds its operands on the ALU for EXEC_CYCLES
// cycles, captures the ALU result/flags and presents them until taken.
// Optional macro ALU_ARB_FIXED_PRIO_EN selects fixed priority (requester 0) instead of round-robin.
module alu_arb_ctrl
  import alu_arb_pkg::*;
#(
  parameter int EXEC_CYCLES = 1,
  parameter int FUN_W       = FUN_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  // requester 0
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [FUN_W-1:0] req0_fun,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic             req0_sign,
  // requester 1
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [FUN_W-1:0] req1_fun,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic             req1_sign,
  // shared ALU
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [FUN_W-1:0] alu_fun,
  output logic             alu_sign,
  input  logic [31:0]      alu_s,
  input  logic             alu_z,
  input  logic             alu_v,
  input  logic             alu_n,
  // response
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [31:0]      rsp_s,
  output logic             rsp_z,
  output logic             rsp_v,
  output logic             rsp_n
);

  localparam logic [CNT_W-1:0] EXEC_LOAD = CNT_W'(EXEC_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [FUN_W-1:0] fun_q, fun_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic             sign_q, sign_d;
  logic             id_q, id_d;
  logic [31:0]      rsp_s_q, rsp_s_d;
  logic             rsp_z_q, rsp_z_d;
  logic             rsp_v_q, rsp_v_d;
  logic             rsp_n_q, rsp_n_d;

  logic             gnt_id;
  logic             accept;

  alu_arb_grant u_grant (
    .clk      (clk),
    .reset    (reset),
    .valid0_i (req0_valid),
    .valid1_i (req1_valid),
    .accept_i (accept),
    .gnt_id_o (gnt_id)
  );

  // Next-state, handshake and capture logic for the IDLE/EXEC/RESP sequence.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fun_d      = fun_q;
    a_d        = a_q;
    b_d        = b_q;
    sign_d     = sign_q;
    id_d       = id_q;
    rsp_s_d    = rsp_s_q;
    rsp_z_d    = rsp_z_q;
    rsp_v_d    = rsp_v_q;
    rsp_n_d    = rsp_n_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept     = 1'b0;

    case (state_q)
      IDLE: begin
        req0_ready = req0_valid & ~gnt_id;
        req1_ready = req1_valid & gnt_id;
        accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);
        if (accept) begin
          fun_d   = gnt_id ? req1_fun : req0_fun;
          a_d     = pick32(gnt_id, req0_a, req1_a);
          b_d     = pick32(gnt_id, req0_b, req1_b);
          sign_d  = gnt_id ? req1_sign : req0_sign;
          id_d    = gnt_id;
          cnt_d   = EXEC_LOAD;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          rsp_s_d = alu_s;
          rsp_z_d = alu_z;
          rsp_v_d = alu_v;
          rsp_n_d = alu_n;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counter, operand and response registers; reset drops any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fun_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sign_q  <= 1'b0;
      id_q    <= 1'b0;
      rsp_s_q <= '0;
      rsp_z_q <= 1'b0;
      rsp_v_q <= 1'b0;
      rsp_n_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fun_q   <= fun_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sign_q  <= sign_d;
      id_q    <= id_d;
      rsp_s_q <= rsp_s_d;
      rsp_z_q <= rsp_z_d;
      rsp_v_q <= rsp_v_d;
      rsp_n_q <= rsp_n_d;
    end
  end

  // ALU always sees the operand registers; they only change on acceptance.
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_fun   = fun_q;
  assign alu_sign  = sign_q;

  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = id_q;
  assign rsp_s     = rsp_s_q;
  assign rsp_z     = rsp_z_q;
  assign rsp_v     = rsp_v_q;
  assign rsp_n     = rsp_n_q;

endmodule

// File: tb/tb_alu_arb_ctrl.sv
// Bench for alu_arb_ctrl: two instances (EXEC_CYCLES=1 and 4), each with a stub ALU.
// A transaction-level model predicts ready/response/ALU-drive outputs every cycle;
// directed tests add literal expectations. Honours ALU_ARB_FIXED_PRIO_EN.
module tb_alu_arb_ctrl;

  typedef struct packed {
    logic [31:0] s;
    logic        z;
    logic        v;
    logic        n;
  } res_t;

  // Stub ALU behaviour: difference, zero flag, v = sign ^ fun[1], n = fun[0].
  function automatic res_t alu_ref(input logic [5:0] f, input logic [31:0] a,
                                   input logic [31:0] b, input logic sg);
    res_t r;
    r.s = a - b;
    r.z = (r.s == 32'd0);
    r.v = sg ^ f[1];
    r.n = f[0];
    return r;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst, r0_valid, r1_valid, r0_sign, r1_sign, r0_ready, r1_ready;
  logic [1:0]  alu_sign, alu_z, alu_v, alu_n;
  logic [1:0]  rsp_valid, rsp_ready, rsp_id, rsp_z, rsp_v, rsp_n;
  logic [5:0]  r0_fun [2];
  logic [5:0]  r1_fun [2];
  logic [5:0]  alu_fun [2];
  logic [31:0] r0_a [2];
  logic [31:0] r0_b [2];
  logic [31:0] r1_a [2];
  logic [31:0] r1_b [2];
  logic [31:0] alu_a [2];
  logic [31:0] alu_b [2];
  logic [31:0] alu_s [2];
  logic [31:0] rsp_s [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    alu_arb_ctrl #(.EXEC_CYCLES((gi == 0) ? 1 : 4), .FUN_W(6)) u_dut (
      .clk        (clk),
      .reset      (rst[gi]),
      .req0_valid (r0_valid[gi]),
      .req0_ready (r0_ready[gi]),
      .req0_fun   (r0_fun[gi]),
      .req0_a     (r0_a[gi]),
      .req0_b     (r0_b[gi]),
      .req0_sign  (r0_sign[gi]),
      .req1_valid (r1_valid[gi]),
      .req1_ready (r1_ready[gi]),
      .req1_fun   (r1_fun[gi]),
      .req1_a     (r1_a[gi]),
      .req1_b     (r1_b[gi]),
      .req1_sign  (r1_sign[gi]),
      .alu_a      (alu_a[gi]),
      .alu_b      (alu_b[gi]),
      .alu_fun    (alu_fun[gi]),
      .alu_sign   (alu_sign[gi]),
      .alu_s      (alu_s[gi]),
      .alu_z      (alu_z[gi]),
      .alu_v      (alu_v[gi]),
      .alu_n      (alu_n[gi]),
      .rsp_valid  (rsp_valid[gi]),
      .rsp_ready  (rsp_ready[gi]),
      .rsp_id     (rsp_id[gi]),
      .rsp_s      (rsp_s[gi]),
      .rsp_z      (rsp_z[gi]),
      .rsp_v      (rsp_v[gi]),
      .rsp_n      (rsp_n[gi])
    );
  end

  // Stub ALUs, purely combinational from what each controller drives.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      res_t r;
      r = alu_ref(alu_fun[k], alu_a[k], alu_b[k], alu_sign[k]);
      alu_s[k] = r.s;
      alu_z[k] = r.z;
      alu_v[k] = r.v;
      alu_n[k] = r.n;
    end
  end

  int n_run  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model state: one outstanding operation per instance, timed from its acceptance cycle.
  logic [1:0]  m_known = 2'b00;
  logic [1:0]  m_pend, m_last, m_sign, m_id;
  int          m_acc [2];
  logic [5:0]  m_fun [2];
  logic [31:0] m_a [2];
  logic [31:0] m_b [2];

  // Snapshots of DUT outputs taken at the falling edge of the current cycle.
  logic [1:0]  sn_r0, sn_r1, sn_rv, sn_id, sn_z, sn_n;
  logic [31:0] sn_s [2];
  logic [31:0] sn_a [2];

  task automatic model_step(input int k);
    int   ec;
    logic g, er0, er1, erv;
    res_t r;
    ec = (k == 0) ? 1 : 4;
`ifdef ALU_ARB_FIXED_PRIO_EN
    g = r0_valid[k] ? 1'b0 : r1_valid[k];
`else
    if (r0_valid[k] && r1_valid[k]) g = (m_last[k] == 1'b0);
    else                             g = r1_valid[k];
`endif
    er0 = !m_pend[k] && r0_valid[k] && (g == 1'b0);
    er1 = !m_pend[k] && r1_valid[k] && (g == 1'b1);
    erv = m_pend[k] && ((cyc - m_acc[k]) >= ec + 1);
    r   = alu_ref(m_fun[k], m_a[k], m_b[k], m_sign[k]);

    sn_r0[k] = r0_ready[k];
    sn_r1[k] = r1_ready[k];
    sn_rv[k] = rsp_valid[k];
    sn_id[k] = rsp_id[k];
    sn_z[k]  = rsp_z[k];
    sn_n[k]  = rsp_n[k];
    sn_s[k]  = rsp_s[k];
    sn_a[k]  = alu_a[k];

    if (m_known[k]) begin
      chk($sformatf("u%0d_ready0", k), {31'd0, r0_ready[k]}, {31'd0, er0});
      chk($sformatf("u%0d_ready1", k), {31'd0, r1_ready[k]}, {31'd0, er1});
      chk($sformatf("u%0d_rsp_valid", k), {31'd0, rsp_valid[k]}, {31'd0, erv});
      chk($sformatf("u%0d_alu_a", k), alu_a[k], m_a[k]);
      chk($sformatf("u%0d_alu_b", k), alu_b[k], m_b[k]);
      chk($sformatf("u%0d_alu_fun", k), {26'd0, alu_fun[k]}, {26'd0, m_fun[k]});
      chk($sformatf("u%0d_alu_sign", k), {31'd0, alu_sign[k]}, {31'd0, m_sign[k]});
      if (erv) begin
        chk($sformatf("u%0d_rsp_id", k), {31'd0, rsp_id[k]}, {31'd0, m_id[k]});
        chk($sformatf("u%0d_rsp_s", k), rsp_s[k], r.s);
        chk($sformatf("u%0d_rsp_flags", k), {29'd0, rsp_z[k], rsp_v[k], rsp_n[k]},
            {29'd0, r.z, r.v, r.n});
      end
    end

    if (rst[k]) begin
      m_known[k] = 1'b1;
      m_pend[k]  = 1'b0;
      m_last[k]  = 1'b1;
      m_fun[k]   = '0;
      m_a[k]     = '0;
      m_b[k]     = '0;
      m_sign[k]  = 1'b0;
      m_id[k]    = 1'b0;
    end else if (erv && rsp_ready[k]) begin
      m_pend[k] = 1'b0;
    end else if (er0 || er1) begin
      m_pend[k] = 1'b1;
      m_acc[k]  = cyc;
      m_id[k]   = g;
      m_last[k] = g;
      m_fun[k]  = g ? r1_fun[k] : r0_fun[k];
      m_a[k]    = g ? r1_a[k] : r0_a[k];
      m_b[k]    = g ? r1_b[k] : r0_b[k];
      m_sign[k] = g ? r1_sign[k] : r0_sign[k];
    end
  endtask

  // One clock cycle: compare at the falling edge, then release to just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    for (int k = 0; k < 2; k++) model_step(k);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_inst(input int k);
    rst[k] = 1'b1;
    tick();
    rst[k] = 1'b0;
  endtask

  initial begin
    int          acc0, acc1, nresp, first, seen, got;
    logic [2:0]  ids;

    rst = 2'b11; r0_valid = '0; r1_valid = '0; r0_sign = '0; r1_sign = '0; rsp_ready = 2'b11;
    for (int k = 0; k < 2; k++) begin
      r0_fun[k] = '0; r1_fun[k] = '0; r0_a[k] = '0; r0_b[k] = '0; r1_a[k] = '0; r1_b[k] = '0;
    end
    tick();
    tick();
    rst = 2'b00;
    tick();
    chk("reset_rsp_valid", {31'd0, sn_rv[0]}, 32'd0);
    chk("reset_rsp_s", sn_s[0], 32'd0);
    chk("reset_alu_a", sn_a[1], 32'd0);

    // Single op on EXEC_CYCLES=1: response in cycle 2 with s=0, z=1.
    r0_valid[0] = 1'b1; r0_fun[0] = 6'h31; r0_a[0] = 32'd5; r0_b[0] = 32'd5; r0_sign[0] = 1'b0;
    tick();
    chk("t1_accept", {31'd0, sn_r0[0]}, 32'd1);
    r0_valid[0] = 1'b0;
    tick();
    chk("t1_cyc1_rsp_valid", {31'd0, sn_rv[0]}, 32'd0);
    tick();
    chk("t1_cyc2_rsp_valid", {31'd0, sn_rv[0]}, 32'd1);
    chk("t1_rsp_id", {31'd0, sn_id[0]}, 32'd0);
    chk("t1_rsp_s", sn_s[0], 32'd0);
    chk("t1_rsp_z", {31'd0, sn_z[0]}, 32'd1);
    tick();
    chk("t1_cyc3_rsp_valid", {31'd0, sn_rv[0]}, 32'd0);

    // Both valid right after reset: req0 first, req1 in first IDLE after (cycle 3).
    reset_inst(0);
    r0_valid[0] = 1'b1; r0_fun[0] = 6'h01; r0_a[0] = 32'd10; r0_b[0] = 32'd3; r0_sign[0] = 1'b0;
    r1_valid[0] = 1'b1; r1_fun[0] = 6'h02; r1_a[0] = 32'd7;  r1_b[0] = 32'd7; r1_sign[0] = 1'b1;
    acc0 = -1; acc1 = -1;
    for (int i = 0; i < 20 && (acc0 < 0 || acc1 < 0); i++) begin
      tick();
      if (sn_r0[0] && r0_valid[0]) begin acc0 = i; r0_valid[0] = 1'b0; end
      if (sn_r1[0] && r1_valid[0]) begin acc1 = i; r1_valid[0] = 1'b0; end
    end
    r0_valid[0] = 1'b0; r1_valid[0] = 1'b0;
    chk("t2_req0_accept_cycle", acc0, 32'd0);
    chk("t2_req1_accept_cycle", acc1, 32'd3);
    for (int i = 0; i < 4; i++) tick();

    // Both held valid for three operations: ids alternate, or stay 0 with fixed priority.
    reset_inst(0);
    r0_valid[0] = 1'b1; r1_valid[0] = 1'b1;
    nresp = 0; ids = 3'b111;
    for (int i = 0; i < 40 && nresp < 3; i++) begin
      tick();
      if (sn_rv[0]) begin ids[nresp] = sn_id[0]; nresp++; end
    end
    r0_valid[0] = 1'b0; r1_valid[0] = 1'b0;
    chk("t3_resp_count", nresp, 32'd3);
`ifdef ALU_ARB_FIXED_PRIO_EN
    chk("t3_ids", {29'd0, ids}, 32'b000);
`else
    chk("t3_ids", {29'd0, ids}, 32'b010);
`endif
    for (int i = 0; i < 3; i++) tick();

    // Response held 5 cycles with rsp_ready low: stable, no new acceptance.
    rsp_ready[0] = 1'b0;
    r1_valid[0] = 1'b1; r1_fun[0] = 6'h05; r1_a[0] = 32'd100; r1_b[0] = 32'd1; r1_sign[0] = 1'b1;
    got = 0;
    for (int i = 0; i < 10 && got == 0; i++) begin
      tick();
      if (sn_r1[0]) got = 1;
    end
    chk("t4_accept_req1", got, 32'd1);
    r1_valid[0] = 1'b0;
    r0_valid[0] = 1'b1;
    got = 0;
    for (int i = 0; i < 10 && got == 0; i++) begin
      tick();
      if (sn_rv[0]) got = 1;
    end
    chk("t4_reached_resp", got, 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_hold_valid", {31'd0, sn_rv[0]}, 32'd1);
      chk("t4_hold_s", sn_s[0], 32'd99);
      chk("t4_hold_id", {31'd0, sn_id[0]}, 32'd1);
      chk("t4_hold_ready", {30'd0, sn_r1[0], sn_r0[0]}, 32'd0);
    end
    rsp_ready[0] = 1'b1;
    tick();
    tick();
    chk("t4_accept_after", {31'd0, sn_r0[0]}, 32'd1);
    r0_valid[0] = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    // EXEC_CYCLES=4: response first in cycle 5 with s=1, n=1.
    r0_valid[1] = 1'b1; r0_fun[1] = 6'h03; r0_a[1] = 32'd2; r0_b[1] = 32'd1; r0_sign[1] = 1'b0;
    tick();
    chk("t5_accept", {31'd0, sn_r0[1]}, 32'd1);
    r0_valid[1] = 1'b0;
    first = -1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (sn_rv[1] && first < 0) begin
        first = i;
        chk("t5_rsp_s", sn_s[1], 32'd1);
        chk("t5_rsp_n", {31'd0, sn_n[1]}, 32'd1);
      end
    end
    chk("t5_first_valid_cycle", first, 32'd5);

    // Reset during EXEC drops the operation; no response ever follows.
    r1_valid[1] = 1'b1; r1_fun[1] = 6'h10; r1_a[1] = 32'd9; r1_b[1] = 32'd4; r1_sign[1] = 1'b0;
    tick();
    chk("t6_accept", {31'd0, sn_r1[1]}, 32'd1);
    r1_valid[1] = 1'b0;
    tick();
    reset_inst(1);
    tick();
    chk("t6_after_reset_valid", {31'd0, sn_rv[1]}, 32'd0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen += int'(sn_rv[1]);
    end
    chk("t6_no_response", seen, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arb_ctrl.md
ALU_ARB_CTRL -- requirements
Module: alu_arb_ctrl

Interface
REQ-001 SHALL have parameter EXEC_CYCLES, default 1, meaning ALU settle cycles per operation, legal range 1..15.
REQ-002 SHALL have parameter FUN_W, default 6, meaning ALU function-code width.
REQ-003 SHALL have clk  in  1  single clock, all logic on rising edge.
REQ-004 SHALL have reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have reqN_valid  in  1  request valid from requester N, N=0,1.
REQ-006 SHALL have reqN_ready  out  1  request accepted from requester N.
REQ-007 SHALL have reqN_fun  in  FUN_W  ALU function code from requester N.
REQ-008 SHALL have reqN_a and reqN_b  in  32  operands from requester N.
REQ-009 SHALL have reqN_sign  in  1  signed-compare select from requester N.
REQ-010 SHALL have alu_a and alu_b  out  32  operands to the shared ALU.
REQ-011 SHALL have alu_fun  out  FUN_W  and alu_sign  out  1  to the shared ALU.
REQ-012 SHALL have alu_s  in  32  and alu_z, alu_v, alu_n  in  1 each  ALU result and flags.
REQ-013 SHALL have rsp_valid  out  1, rsp_ready  in  1, rsp_id  out  1 (granted requester).
REQ-014 SHALL have rsp_s  out  32  and rsp_z, rsp_v, rsp_n  out  1 each  registered result and flags.

Function
REQ-015 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-016 In IDLE, reqN_ready SHALL be high combinationally only for the granted requester, and only while that requester's valid is high.
REQ-017 A transfer SHALL occur on reqN_valid && reqN_ready; fun/a/b/sign and id SHALL be captured and the FSM SHALL move to EXEC, loading the counter with EXEC_CYCLES-1.
REQ-018 alu_* outputs SHALL be driven from the operand registers at all times; the operands SHALL be stable throughout EXEC.
REQ-019 In EXEC, the counter SHALL decrement each cycle; at count 0, alu_s/z/v/n SHALL be captured into rsp_* and the FSM SHALL move to RESP.
REQ-020 Latency: if accepted in cycle 0, rsp_valid SHALL first be high in cycle EXEC_CYCLES+1.
REQ-021 In RESP, rsp_valid SHALL be high and rsp_* and rsp_id SHALL stay stable until rsp_ready; on handshake the FSM SHALL return to IDLE.
REQ-022 No request SHALL be accepted outside IDLE; both reqN_ready SHALL be low in EXEC and RESP.
REQ-023 Round-robin: if both requests are valid in IDLE, the grant SHALL go to the requester not granted last; the last-grant pointer SHALL update on request acceptance.
REQ-024 With a single valid requester, that requester SHALL be granted regardless of the pointer.
REQ-025 The controller SHALL perform no arithmetic; sign and flags SHALL pass through unmodified.

Reset
REQ-026 When reset is high, the FSM SHALL be IDLE, counter 0, operand and rsp registers 0, rsp_valid 0, and last-grant set so requester 0 wins the first tie.
REQ-027 Reset during EXEC or RESP SHALL drop the in-flight operation; no response SHALL be emitted for it.

Configuration
REQ-028 If ALU_ARB_FIXED_PRIO_EN is defined, requester 0 SHALL always win ties and the pointer SHALL be absent; if undefined, round-robin per REQ-023 SHALL apply.

Structure
REQ-029 A shared header alu_arb_pkg SHALL hold the state encodings (IDLE=0, EXEC=1, RESP=2, 2 bits), the FUN_W default and the counter width (4).
REQ-030 Grant logic and pointer SHALL be one sub-module alu_arb_grant; the ALU itself SHALL remain external.

Verification
REQ-031 Req0 fun=6'h31, a=5, b=5, EXEC_CYCLES=1, ALU returns s=0, z=1 -> rsp_valid in cycle 2, rsp_id=0, rsp_s=0, rsp_z=1.
REQ-032 Both requests valid in cycle 0 after reset -> req0 granted first; req1 granted in the first IDLE after the req0 response completes.
REQ-033 rsp_ready held low 5 cycles in RESP -> rsp_* stable; both reqN_ready stay low; no new acceptance.
REQ-034 EXEC_CYCLES=4, ALU returns s=1, n=1 -> rsp_valid first high in cycle 5, rsp_s=1, rsp_n=1.
REQ-035 Reset asserted in EXEC -> next cycle IDLE with rsp_valid=0 and no response ever emitted for the dropped operation.
REQ-036 Build with ALU_ARB_FIXED_PRIO_EN and hold both requests valid for 3 operations -> rsp_id=0 every time.
